// File: rtl/seq_mul4.sv
// seq_mul4: sequential 4x4 unsigned multiplier. Feeds the 2x2 mux-based
// multiplier one digit pair per clock and shift-accumulates into 8 bits.

module with_mux (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f3,
  output logic f2,
  output logic f1,
  output logic f0
);
  // {a,b} * {c,d}, each output bit selected by the multiplier digit
  assign f0 = d ? b : 1'b0;
  assign f1 = c ? (d ? (a ^ b) : b) : (d ? a : 1'b0);
  assign f2 = c ? (d ? (a & ~b) : a) : 1'b0;
  assign f3 = (c & d) ? (a & b) : 1'b0;
endmodule

module seq_mul4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  // state | meaning
  // IDLE  | waiting for start; product holds the last result
  // RUN   | one digit pair per clock, step selects the pair (0..3)
  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nxt;
  logic [1:0] step;
  logic [3:0] x_reg, y_reg;
  logic [7:0] acc;
  logic [1:0] x_dig, y_dig;
  logic [3:0] pp;
  logic [7:0] term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (step == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // step0: X0*Y0, step1: X0*Y1, step2: X1*Y0, step3: X1*Y1
  assign x_dig = step[1] ? x_reg[3:2] : x_reg[1:0];
  assign y_dig = step[0] ? y_reg[3:2] : y_reg[1:0];

  with_mux u_mul (
    .a  (x_dig[1]),
    .b  (x_dig[0]),
    .c  (y_dig[1]),
    .d  (y_dig[0]),
    .f3 (pp[3]),
    .f2 (pp[2]),
    .f1 (pp[1]),
    .f0 (pp[0])
  );

  always_comb begin
    term = {4'b0000, pp};
    case (step)
      2'd0:    term = {4'b0000, pp};
      2'd3:    term = {pp, 4'b0000};
      default: term = {2'b00, pp, 2'b00};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step    <= 2'd0;
      x_reg   <= 4'd0;
      y_reg   <= 4'd0;
      acc     <= 8'd0;
      product <= 8'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          x_reg <= x_in;
          y_reg <= y_in;
          acc   <= 8'd0;
          step  <= 2'd0;
        end
      end else begin
        acc  <= acc + term;
        step <= step + 2'd1;
        if (step == 2'd3) begin
          product <= acc + term;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule
